// File: rtl/oram_path_sequencer.sv
// oram_path_sequencer: sequences one oblivious access (posmap lookup/remap, root-to-leaf read pass, leaf-to-root eviction).
// Define ORAM_SEQ_DUMMY_ACCESS_EN to start dummy path accesses after IDLE_TIMEOUT idle cycles.
module oram_path_sequencer #(
  parameter int D = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int IDLE_TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [D-1:0]         req_block,
  input  logic                 req_write,
  output logic                 pm_re,
  output logic [D-1:0]         pm_addr,
  input  logic [D-1:0]         pm_rd_data,
  output logic                 pm_we,
  output logic [D-1:0]         pm_wr_data,
  output logic                 mem_req,
  input  logic                 mem_gnt,
  output logic                 mem_we,
  output logic [D-1:0]         mem_bucket,
  output logic [$clog2(D)-1:0] mem_level,
  output logic [D-2:0]         op_leaf,
  output logic [D-2:0]         op_new_leaf,
  output logic [D-1:0]         op_block,
  output logic                 op_write,
  output logic                 serve,
  output logic                 dummy,
  output logic                 done
);
  localparam int LV = $clog2(D);
  typedef enum logic [2:0] {IDLE, PM_WAIT, READ_PATH, SERVE, WRITE_PATH, DONE} state_t;
  state_t state, state_nx;
  logic [LV-1:0] level;
  logic [15:0] lfsr;
  logic dummy_go, dummy_q;
`ifdef ORAM_SEQ_DUMMY_ACCESS_EN
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  logic [CW-1:0] idle_cnt;
  assign dummy_go = state == IDLE && !req_valid && idle_cnt == CW'(IDLE_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idle_cnt <= '0;
      dummy_q <= 1'b0;
    end else begin
      idle_cnt <= (state == IDLE && !req_valid && !dummy_go) ? idle_cnt + 1'b1 : '0;
      dummy_q <= state == IDLE ? dummy_go : state == DONE ? 1'b0 : dummy_q;
    end
`else
  assign dummy_go = 1'b0;
  assign dummy_q = 1'b0;
`endif
  assign dummy = dummy_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       state_nx = req_valid ? PM_WAIT : dummy_go ? READ_PATH : IDLE;
      PM_WAIT:    state_nx = READ_PATH;
      READ_PATH:  state_nx = (mem_gnt && level == LV'(D - 1)) ? (dummy_q ? WRITE_PATH : SERVE) : READ_PATH;
      SERVE:      state_nx = WRITE_PATH;
      WRITE_PATH: state_nx = (mem_gnt && level == '0) ? DONE : WRITE_PATH;
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end
  // Leaf LFSR steps only when an access (real or dummy) starts.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
      level <= '0;
      op_leaf <= '0;
      op_new_leaf <= '0;
      op_block <= '0;
      op_write <= 1'b0;
    end else begin
      if (state == IDLE) level <= '0;
      if (state == IDLE && (req_valid || dummy_go)) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (state == IDLE && req_valid) begin
        op_block <= req_block;
        op_write <= req_write;
        op_new_leaf <= lfsr[D-2:0];
      end
      if (dummy_go) op_leaf <= lfsr[D-2:0];
      if (state == PM_WAIT) op_leaf <= pm_rd_data[D-1] ? pm_rd_data[D-2:0] : op_new_leaf;
      if (state == READ_PATH && mem_gnt && level != LV'(D - 1)) level <= level + 1'b1;
      if (state == WRITE_PATH && mem_gnt && level != '0) level <= level - 1'b1;
    end
  always_comb begin
    req_ready = state == IDLE;
    pm_re = state == IDLE && req_valid;
    pm_we = state == PM_WAIT;
    pm_addr = pm_re ? req_block : pm_we ? op_block : '0;
    pm_wr_data = pm_we ? {1'b1, op_new_leaf} : '0;
    mem_req = state == READ_PATH || state == WRITE_PATH;
    mem_we = state == WRITE_PATH;
    mem_level = mem_req ? level : '0;
    mem_bucket = mem_req ? ((D'(1) << level) | (D'(op_leaf) >> (LV'(D - 1) - level))) : '0;
    serve = state == SERVE;
    done = state == DONE && !dummy_q;
  end
endmodule

// File: tb/tb_oram_path_sequencer.sv
// tb_oram_path_sequencer: directed/randomized accesses checked against a path-walk reference model.
module tb_oram_path_sequencer;
  localparam int D = 6;
  localparam int LV = $clog2(D);
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 0, rst_n = 0, req_valid = 0, req_write = 0, mem_gnt = 0;
  logic [D-1:0] req_block = '0, pm_rd_data = '0;
  logic req_ready, pm_re, pm_we, mem_req, mem_we, op_write, serve, dummy, done;
  logic [D-1:0] pm_addr, pm_wr_data, mem_bucket, op_block;
  logic [LV-1:0] mem_level;
  logic [D-2:0] op_leaf, op_new_leaf;
  logic [15:0] lfsr_m;
  int total = 0, passed = 0;

  oram_path_sequencer #(.D(D), .LFSR_SEED(SEED), .IDLE_TIMEOUT(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_block(req_block), .req_write(req_write), .pm_re(pm_re), .pm_addr(pm_addr),
    .pm_rd_data(pm_rd_data), .pm_we(pm_we), .pm_wr_data(pm_wr_data), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_bucket(mem_bucket), .mem_level(mem_level),
    .op_leaf(op_leaf), .op_new_leaf(op_new_leaf), .op_block(op_block), .op_write(op_write),
    .serve(serve), .dummy(dummy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Ancestor at depth lv of the leaf node (leaf nodes occupy heap indices 2^(D-1)..2^D-1).
  function automatic logic [D-1:0] path_node(input logic [D-2:0] leaf, input int lv);
    logic [D-1:0] n;
    n = {1'b1, leaf};
    return n >> (D - 1 - lv);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic reset_checks(input string t);
    chk({t, "_ready"}, req_ready, 1);
    chk({t, "_pm_re"}, pm_re, 0);
    chk({t, "_pm_addr"}, pm_addr, 0);
    chk({t, "_pm_we"}, pm_we, 0);
    chk({t, "_pm_wr_data"}, pm_wr_data, 0);
    chk({t, "_mem"}, {mem_req, mem_we, mem_bucket, mem_level}, 0);
    chk({t, "_op"}, {op_leaf, op_new_leaf, op_block, op_write}, 0);
    chk({t, "_strobes"}, {serve, dummy, done}, 0);
  endtask

  task automatic do_access(input logic [D-1:0] blk, input logic wr, input logic mapped,
                           input logic [D-2:0] pl, input int stall_lvl, input int stall_n,
                           input int abort_lvl, input logic hold, input logic [D-1:0] nb);
    logic [D-2:0] nl, leaf;
    int cyc;
    chk("accept_ready", req_ready, 1);
    nl = lfsr_m[D-2:0];
    lfsr_m = lfsr_step(lfsr_m);
    req_valid = 1; req_block = blk; req_write = wr;
    #1;
    chk("pm_re", pm_re, 1);
    chk("pm_addr_idle", pm_addr, blk);
    @(posedge clk); #1; cyc = 1;
    req_valid = hold; req_block = hold ? nb : D'($urandom); req_write = 1'($urandom);
    chk("pm_we", pm_we, 1);
    chk("pm_addr_wr", pm_addr, blk);
    chk("pm_wr_data", pm_wr_data, {1'b1, nl});
    chk("op_new_leaf", op_new_leaf, nl);
    chk("op_block", op_block, blk);
    chk("op_write", op_write, wr);
    chk("busy_ready", req_ready, 0);
    pm_rd_data = {mapped, pl};
    mem_gnt = 1'($urandom);
    leaf = mapped ? pl : nl;
    for (int i = 0; i < 2 * D; i++) begin
      int lv, waits;
      logic we;
      lv = i < D ? i : 2 * D - 1 - i;
      we = i >= D;
      waits = (!we && lv == stall_lvl) ? stall_n : 0;
      if (i == D) begin
        @(posedge clk); #1; cyc++;
        chk("serve", {serve, mem_req, done}, 3'b100);
        mem_gnt = 1'($urandom);
      end
      for (int s = 0; s <= waits; s++) begin
        @(posedge clk); #1; cyc++;
        pm_rd_data = D'($urandom);
        if (!we && lv == abort_lvl) begin
          req_valid = 0;
          rst_n = 0;
          #1;
          reset_checks("async_rst");
          return;
        end
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, we);
        chk("mem_bucket", mem_bucket, path_node(leaf, lv));
        chk("mem_level", mem_level, lv);
        chk("op_leaf", op_leaf, leaf);
        chk("walk_quiet", {serve, done, pm_we, req_ready}, 0);
        mem_gnt = (s == waits);
      end
    end
    @(posedge clk); #1; cyc++;
    mem_gnt = 1'($urandom);
    chk("done", {done, mem_req, serve}, 3'b100);
    chk("done_cycle", cyc, 2 * D + 3 + ((stall_lvl >= 0 && stall_lvl < D) ? stall_n : 0));
    chk("done_op", {op_block, op_write}, {blk, wr});
    @(posedge clk); #1;
    chk("ready_again", {req_ready, done}, 2'b10);
  endtask

  initial begin
    logic [D-1:0] b, nb;
    lfsr_m = SEED;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n = 1;
    @(posedge clk); #1;
    // Mapped block read, grant tied high.
    do_access(6'h2A, 0, 1, 5'b10110, -1, 0, -1, 0, '0);
    // Reset mid read pass at level 3.
    do_access(D'($urandom), 1, 1, 5'($urandom), -1, 0, 3, 0, '0);
    @(posedge clk); #1;
    reset_checks("rst_held");
    rst_n = 1;
    lfsr_m = SEED;
    @(posedge clk); #1;
    // First-touch write, with a second request held pending throughout.
    b = D'($urandom);
    nb = D'($urandom);
    do_access(b, 1, 0, 5'($urandom), -1, 0, -1, 1, nb);
    chk("first_touch_leaf", op_leaf, 5'h01);
    chk("first_touch_write", op_write, 1);
    // Held request accepted at cycle 16, with a 4-cycle grant stall at read level 2.
    do_access(nb, 0, 1, 5'($urandom), 2, 4, -1, 0, '0);
    chk("second_leaf", op_new_leaf, 5'h03);
    for (int k = 0; k < 3; k++)
      do_access(D'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                int'($urandom_range(0, D - 1)), int'($urandom_range(0, 3)), -1, 0, '0);
`ifdef ORAM_SEQ_DUMMY_ACCESS_EN
    begin
      int n;
      logic [D-2:0] dl;
      n = 0;
      mem_gnt = 1;
      while (n < 40 && !mem_req) begin
        @(posedge clk); #1; n++;
      end
      chk("dummy_start", n, 32);
      dl = lfsr_m[D-2:0];
      lfsr_m = lfsr_step(lfsr_m);
      b = D'($urandom);
      for (int i = 0; i < 2 * D; i++) begin
        int lv;
        lv = i < D ? i : 2 * D - 1 - i;
        if (i > 0) begin @(posedge clk); #1; end
        if (i == 2) begin req_valid = 1; req_block = b; req_write = 0; end
        chk("dummy_flag", dummy, 1);
        chk("dummy_bucket", mem_bucket, path_node(dl, lv));
        chk("dummy_we", {mem_req, mem_we}, {1'b1, i >= D});
        chk("dummy_quiet", {pm_we, serve, done, req_ready}, 0);
      end
      @(posedge clk); #1;
      chk("dummy_done", {done, dummy, mem_req}, 3'b010);
      @(posedge clk); #1;
      do_access(b, 0, 1, 5'($urandom), -1, 0, -1, 0, '0);
    end
`else
    mem_gnt = 1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      chk("idle_quiet", {dummy, mem_req, req_ready}, 3'b001);
    end
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
